// File: rtl/md_sched_if.sv
// Handshake bundle between the E/D pipeline stages and the multiply/divide scheduler.
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        hi_lo_sel;
  logic        md_in_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, md_a, md_b, hi_lo_sel, md_in_d,
    input  busy, stall_md, md_out, hi, lo
  );

  modport slave (
    input  start, md_op, md_a, md_b, hi_lo_sel, md_in_d,
    output busy, stall_md, md_out, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler for the 5-stage MIPS pipeline.
// Owns HI/LO, runs mult/div ops for a fixed latency and stalls D-stage MD instructions.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic [63:0]      prod_s;
  logic [63:0]      prod_u;
  logic [31:0]      safe_b;
  logic [31:0]      mag_a;
  logic [31:0]      mag_b;
  logic [31:0]      mag_q;
  logic [31:0]      mag_r;
  logic [31:0]      sdiv_q;
  logic [31:0]      sdiv_r;
  logic [31:0]      udiv_q;
  logic [31:0]      udiv_r;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_we;
  logic             op_is_md;

  // Result datapath from the latched operands; signed divide goes through magnitudes
  // so that 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    safe_b = (b_q == 32'd0) ? 32'd1 : b_q;
    mag_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    mag_b  = b_q[31] ? (32'd0 - b_q) : safe_b;
    mag_q  = mag_a / mag_b;
    mag_r  = mag_a % mag_b;
    sdiv_q = (a_q[31] ^ b_q[31]) ? (32'd0 - mag_q) : mag_q;
    sdiv_r = a_q[31] ? (32'd0 - mag_r) : mag_r;
    udiv_q = a_q / safe_b;
    udiv_r = a_q % safe_b;
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_we = 1'b1; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_we = 1'b1; end
      OP_DIV:   begin res_hi = sdiv_r; res_lo = sdiv_q; res_we = (b_q != 32'd0); end
      OP_DIVU:  begin res_hi = udiv_r; res_lo = udiv_q; res_we = (b_q != 32'd0); end
      default:  res_we = 1'b0;
    endcase
  end

  // Control FSM: accepts ops when idle, counts down the latency, commits HI/LO at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      op_q   <= 3'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              OP_MULT, OP_MULTU: begin
                op_q   <= bus.md_op;
                a_q    <= bus.md_a;
                b_q    <= bus.md_b;
                cnt    <= CNT_W'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q   <= bus.md_op;
                a_q    <= bus.md_a;
                b_q    <= bus.md_b;
                cnt    <= CNT_W'(DIV_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              OP_MTHI: hi_q <= bus.md_a;
              OP_MTLO: lo_q <= bus.md_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            if (res_we) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall any MD instruction in D while the unit is busy or an MD op is issuing from E.
  always_comb begin
    op_is_md     = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_MTLO);
    bus.stall_md = bus.md_in_d & (busy_q | (bus.start & op_is_md));
    bus.busy     = busy_q;
    bus.hi       = hi_q;
    bus.lo       = lo_q;
    bus.md_out   = bus.hi_lo_sel ? lo_q : hi_q;
  end

endmodule

// File: tb/tb_md_sched.sv
// Randomized and directed bench for md_sched against an arithmetic reference model.
module tb_md_sched;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  md_sched_if bus ();

  md_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic d);
    bus.start   = s;
    bus.md_op   = op;
    bus.md_a    = a;
    bus.md_b    = b;
    bus.md_in_d = d;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
  task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = longint'(sa * sb); model_hi = p[63:32]; model_lo = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; model_hi = p[63:32]; model_lo = p[31:0]; end
      3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; model_lo = q[31:0]; model_hi = r[31:0]; end
      3'd4: if (b != 32'd0) begin model_lo = a / b; model_hi = a % b; end
      3'd5: model_hi = a;
      3'd6: model_lo = a;
      default: ;
    endcase
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic d, input logic inject);
    int lat;
    int n;
    logic [31:0] pre_hi;
    pre_hi = model_hi;
    lat = (op == 3'd1 || op == 3'd2) ? 5 : ((op == 3'd3 || op == 3'd4) ? 10 : 0);
    applyStimulus(1'b1, op, a, b, d);
    #1;
    checkOutput({tag, " stall_start"}, 32'(bus.stall_md), 32'(d && op >= 3'd1 && op <= 3'd6));
    stepCycle();
    applyStimulus(1'b0, 3'd0, $urandom, $urandom, d);
    #1;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      checkOutput({tag, " stall_busy"}, 32'(bus.stall_md), 32'(d));
      checkOutput({tag, " hi_hold"}, bus.hi, pre_hi);
      applyStimulus(inject && n == 2, 3'd2, $urandom, $urandom, d);
      stepCycle();
    end
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, d);
    #1;
    modelOp(op, a, b);
    checkOutput({tag, " latency"}, 32'(n), 32'(lat));
    checkOutput({tag, " stall_done"}, 32'(bus.stall_md), 32'd0);
    checkOutput({tag, " hi"}, bus.hi, model_hi);
    checkOutput({tag, " lo"}, bus.lo, model_lo);
    bus.hi_lo_sel = 1'b0;
    #1;
    checkOutput({tag, " md_out_hi"}, bus.md_out, model_hi);
    bus.hi_lo_sel = 1'b1;
    #1;
    checkOutput({tag, " md_out_lo"}, bus.md_out, model_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    // Reset state
    reset = 1'b1;
    bus.hi_lo_sel = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst hi", bus.hi, 32'd0);
    checkOutput("rst lo", bus.lo, 32'd0);
    checkOutput("rst stall", 32'(bus.stall_md), 32'd0);
    checkOutput("rst md_out", bus.md_out, 32'd0);
    applyStimulus(1'b1, 3'd1, 32'd3, 32'd4, 1'b1);
    #1;
    checkOutput("rst stall_comb", 32'(bus.stall_md), 32'd1);
    stepCycle();
    checkOutput("rst no_start", 32'(bus.busy), 32'd0);
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    stepCycle();

    // Directed cases
    runOp("mult", 3'd1, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
    checkOutput("mult hi_lit", bus.hi, 32'hFFFFFFFF);
    checkOutput("mult lo_lit", bus.lo, 32'hFFFFFFEB);

    runOp("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("multu hi_lit", bus.hi, 32'hFFFFFFFE);
    checkOutput("multu lo_lit", bus.lo, 32'h00000001);

    runOp("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    checkOutput("div lo_lit", bus.lo, 32'hFFFFFFFD);
    checkOutput("div hi_lit", bus.hi, 32'hFFFFFFFF);

    runOp("mthi11", 3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
    runOp("mtlo22", 3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
    runOp("divu0", 3'd4, 32'd123, 32'd0, 1'b0, 1'b0);
    checkOutput("divu0 hi_lit", bus.hi, 32'h11);
    checkOutput("divu0 lo_lit", bus.lo, 32'h22);

    runOp("mthi", 3'd5, 32'h12345678, 32'd0, 1'b1, 1'b0);
    bus.hi_lo_sel = 1'b0;
    #1;
    checkOutput("mthi md_out_lit", bus.md_out, 32'h12345678);

    runOp("divovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("divovf lo_lit", bus.lo, 32'h80000000);
    checkOutput("divovf hi_lit", bus.hi, 32'h00000000);

    runOp("inject", 3'd1, 32'h00012345, 32'hFFFF0003, 1'b1, 1'b1);
    runOp("op0", 3'd0, 32'hDEADBEEF, 32'd5, 1'b1, 1'b0);

    // Reset in the middle of a run discards the result and clears HI/LO
    stepCycle();
    applyStimulus(1'b1, 3'd1, 32'h7, 32'h9, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("midrst busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    checkOutput("midrst busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst hi", bus.hi, 32'd0);
    checkOutput("midrst lo", bus.lo, 32'd0);
    stepCycle();

    // Randomized ops
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
      runOp($sformatf("rnd%0d", i), op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
